// File: rtl/l2_port_arbiter.sv
// Two-requester (dcache=c0, icache=c1) arbiter for the single L2 port, with write-back/allocate
// locking and a sticky hung-L2 watchdog. Optional grant/wait counters under ARB_PERF_CNT_EN.
module l2_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 1024,
  parameter int WB_LOCK     = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              c0_req_valid_i,
  input  logic              c0_req_rw_i,
  input  logic [ADDR_W-1:0] c0_req_addr_i,
  input  logic [LINE_W-1:0] c0_req_data_i,
  output logic              c0_res_ready_o,
  output logic [LINE_W-1:0] c0_res_data_o,
  input  logic              c1_req_valid_i,
  input  logic              c1_req_rw_i,
  input  logic [ADDR_W-1:0] c1_req_addr_i,
  input  logic [LINE_W-1:0] c1_req_data_i,
  output logic              c1_res_ready_o,
  output logic [LINE_W-1:0] c1_res_data_o,
  output logic              l2_req_valid_o,
  output logic              l2_req_rw_o,
  output logic [ADDR_W-1:0] l2_req_addr_o,
  output logic [LINE_W-1:0] l2_req_data_o,
  input  logic              l2_res_ready_i,
  input  logic [LINE_W-1:0] l2_res_data_i,
  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic              err_timeout_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       c0_grant_cnt_o,
  output logic [31:0]       c1_grant_cnt_o,
  output logic [31:0]       wait_cnt_o
`endif
);

  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_BUSY   = 1'b1;
  localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT_CYC);

  logic [0:0]  state_q;
  logic        owner_q;
  logic        rr_last_q;
  logic [15:0] wdog_q;
  logic        err_q;

  logic        busy;
  logic        own_valid;
  logic        own_rw;
  logic        any_req;
  logic        both_req;
  logic        arb_pick;
  logic        lock_hold;
  logic [15:0] wdog_inc;

  function automatic logic [15:0] wdog_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign busy      = (state_q == S_BUSY);
  assign own_valid = owner_q ? c1_req_valid_i : c0_req_valid_i;
  assign own_rw    = owner_q ? c1_req_rw_i : c0_req_rw_i;
  assign any_req   = c0_req_valid_i | c1_req_valid_i;
  assign both_req  = c0_req_valid_i & c1_req_valid_i;
  // On a tie the requester not served last wins; a lone c1 request picks 1, a lone c0 picks 0.
  assign arb_pick  = both_req ? ~rr_last_q : c1_req_valid_i;
  assign lock_hold = (WB_LOCK != 0) && own_rw;
  assign wdog_inc  = wdog_sat_inc(wdog_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      wdog_q    <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q <= S_BUSY;
            owner_q <= arb_pick;
            wdog_q  <= 16'd0;
          end
        end
        default: begin
          if (!own_valid) begin
            state_q <= S_IDLE;
          end else if (l2_res_ready_i) begin
            rr_last_q <= owner_q;
            if (!lock_hold) state_q <= S_IDLE;
          end
          if (l2_res_ready_i) begin
            wdog_q <= 16'd0;
          end else begin
            wdog_q <= wdog_inc;
            if (wdog_inc >= WDOG_LIM) err_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Forwarding is purely combinational, so an owner dropping valid vanishes downstream at once.
  always_comb begin
    l2_req_valid_o = busy & own_valid;
    l2_req_rw_o    = busy & own_rw;
    l2_req_addr_o  = '0;
    l2_req_data_o  = '0;
    c0_res_data_o  = '0;
    c1_res_data_o  = '0;
    if (busy) begin
      l2_req_addr_o = owner_q ? c1_req_addr_i : c0_req_addr_i;
      l2_req_data_o = owner_q ? c1_req_data_i : c0_req_data_i;
      c0_res_data_o = l2_res_data_i;
      c1_res_data_o = l2_res_data_i;
    end
    c0_res_ready_o = busy & ~owner_q & l2_res_ready_i;
    c1_res_ready_o = busy & owner_q & l2_res_ready_i;
    grant_o        = busy ? {owner_q, ~owner_q} : 2'b00;
    busy_o         = busy;
    err_timeout_o  = err_q;
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] c0_cnt_q;
  logic [31:0] c1_cnt_q;
  logic [31:0] wait_cnt_q;
  logic        waiting;

  assign waiting = busy ? (owner_q ? c0_req_valid_i : c1_req_valid_i) : both_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c0_cnt_q   <= 32'd0;
      c1_cnt_q   <= 32'd0;
      wait_cnt_q <= 32'd0;
    end else begin
      if (!busy && any_req) begin
        if (arb_pick) c1_cnt_q <= c1_cnt_q + 32'd1;
        else          c0_cnt_q <= c0_cnt_q + 32'd1;
      end
      if (waiting) wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign c0_grant_cnt_o = c0_cnt_q;
  assign c1_grant_cnt_o = c1_cnt_q;
  assign wait_cnt_o     = wait_cnt_q;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: expected L2 transactions are queued as requests are
// driven and checked when the arbiter completes them. A second instance runs with WB_LOCK=0.
module tb_l2_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;

  typedef struct packed {
    logic          who;
    logic          rw;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;

  logic clk_i, rst_ni;
  logic c0_req_valid_i, c0_req_rw_i, c1_req_valid_i, c1_req_rw_i;
  logic [AW-1:0] c0_req_addr_i, c1_req_addr_i;
  logic [LW-1:0] c0_req_data_i, c1_req_data_i;
  logic c0_res_ready_o, c1_res_ready_o;
  logic [LW-1:0] c0_res_data_o, c1_res_data_o;
  logic l2_req_valid_o, l2_req_rw_o, l2_res_ready_i;
  logic [AW-1:0] l2_req_addr_o;
  logic [LW-1:0] l2_req_data_o, l2_res_data_i;
  logic [1:0] grant_o;
  logic busy_o, err_timeout_o;

  logic n_c0_valid, n_c0_rw, n_c1_valid, n_c1_rw;
  logic [AW-1:0] n_c0_addr, n_c1_addr;
  logic [LW-1:0] n_c0_data, n_c1_data;
  logic n_c0_ready, n_c1_ready;
  logic [LW-1:0] n_c0_rdata, n_c1_rdata;
  logic n_l2_valid, n_l2_rw, n_l2_ready;
  logic [AW-1:0] n_l2_addr;
  logic [LW-1:0] n_l2_wdata, n_l2_rdata;
  logic [1:0] n_grant;
  logic n_busy, n_err;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] c0_grant_cnt_o, c1_grant_cnt_o, wait_cnt_o;
  logic [31:0] n_c0_cnt, n_c1_cnt, n_wait_cnt;
`endif

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(8), .WB_LOCK(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .c0_req_valid_i(c0_req_valid_i), .c0_req_rw_i(c0_req_rw_i),
    .c0_req_addr_i(c0_req_addr_i), .c0_req_data_i(c0_req_data_i),
    .c0_res_ready_o(c0_res_ready_o), .c0_res_data_o(c0_res_data_o),
    .c1_req_valid_i(c1_req_valid_i), .c1_req_rw_i(c1_req_rw_i),
    .c1_req_addr_i(c1_req_addr_i), .c1_req_data_i(c1_req_data_i),
    .c1_res_ready_o(c1_res_ready_o), .c1_res_data_o(c1_res_data_o),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_rw_o(l2_req_rw_o),
    .l2_req_addr_o(l2_req_addr_o), .l2_req_data_o(l2_req_data_o),
    .l2_res_ready_i(l2_res_ready_i), .l2_res_data_i(l2_res_data_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_timeout_o(err_timeout_o)
`ifdef ARB_PERF_CNT_EN
    , .c0_grant_cnt_o(c0_grant_cnt_o), .c1_grant_cnt_o(c1_grant_cnt_o), .wait_cnt_o(wait_cnt_o)
`endif
  );

  l2_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(8), .WB_LOCK(0)) dut_nl (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .c0_req_valid_i(n_c0_valid), .c0_req_rw_i(n_c0_rw),
    .c0_req_addr_i(n_c0_addr), .c0_req_data_i(n_c0_data),
    .c0_res_ready_o(n_c0_ready), .c0_res_data_o(n_c0_rdata),
    .c1_req_valid_i(n_c1_valid), .c1_req_rw_i(n_c1_rw),
    .c1_req_addr_i(n_c1_addr), .c1_req_data_i(n_c1_data),
    .c1_res_ready_o(n_c1_ready), .c1_res_data_o(n_c1_rdata),
    .l2_req_valid_o(n_l2_valid), .l2_req_rw_o(n_l2_rw),
    .l2_req_addr_o(n_l2_addr), .l2_req_data_o(n_l2_wdata),
    .l2_res_ready_i(n_l2_ready), .l2_res_data_i(n_l2_rdata),
    .grant_o(n_grant), .busy_o(n_busy), .err_timeout_o(n_err)
`ifdef ARB_PERF_CNT_EN
    , .c0_grant_cnt_o(n_c0_cnt), .c1_grant_cnt_o(n_c1_cnt), .wait_cnt_o(n_wait_cnt)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    c0_req_valid_i = 0; c0_req_rw_i = 0; c0_req_addr_i = '0; c0_req_data_i = '0;
    c1_req_valid_i = 0; c1_req_rw_i = 0; c1_req_addr_i = '0; c1_req_data_i = '0;
    l2_res_ready_i = 0; l2_res_data_i = '0;
    n_c0_valid = 0; n_c0_rw = 0; n_c0_addr = '0; n_c0_data = '0;
    n_c1_valid = 0; n_c1_rw = 0; n_c1_addr = '0; n_c1_data = '0;
    n_l2_ready = 0; n_l2_rdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    sb.delete();
    rst_ni = 0;
    tick(); tick();
    rst_ni = 1;
    tick();
  endtask

  // L2 model: wait for the forwarded request, stall, then complete it against the queue head.
  task automatic complete(input int stall, input logic [LW-1:0] rdata);
    exp_t e;
    int n;
    logic [1:0] gexp;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: queue size=%0d required >0", sb.size());
      return;
    end
    e = sb.pop_front();
    gexp = e.who ? 2'b10 : 2'b01;
    n = 0;
    while (l2_req_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (l2_req_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL wait_req: l2_req_valid_o=%b required 1 after %0d cycles", l2_req_valid_o, n);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      total++;
      if ({c0_res_ready_o, c1_res_ready_o} !== 2'b00) begin
        bad++;
        $display("FAIL stall_ready: c0=%b c1=%b required 0 0", c0_res_ready_o, c1_res_ready_o);
      end
    end
    l2_res_data_i = rdata;
    l2_res_ready_i = 1;
    #1;
    total++;
    if (grant_o !== gexp) begin
      bad++;
      $display("FAIL grant: grant_o=%b required %b", grant_o, gexp);
    end
    total++;
    if (l2_req_addr_o !== e.addr || l2_req_rw_o !== e.rw) begin
      bad++;
      $display("FAIL fwd_req: addr=%h rw=%b required addr=%h rw=%b", l2_req_addr_o, l2_req_rw_o, e.addr, e.rw);
    end
    if (e.rw) begin
      total++;
      if (l2_req_data_o !== e.data) begin
        bad++;
        $display("FAIL fwd_wdata: got %h required %h", l2_req_data_o, e.data);
      end
    end
    total++;
    if ({c1_res_ready_o, c0_res_ready_o} !== gexp) begin
      bad++;
      $display("FAIL res_route: {c1,c0}_res_ready=%b%b required %b", c1_res_ready_o, c0_res_ready_o, gexp);
    end
    total++;
    if ((e.who ? c1_res_data_o : c0_res_data_o) !== rdata) begin
      bad++;
      $display("FAIL res_data: got %h required %h", e.who ? c1_res_data_o : c0_res_data_o, rdata);
    end
    tick();
    l2_res_ready_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1;
    #2;
    rst_ni = 0;
    #2;
    total++;
    if ({grant_o, busy_o, err_timeout_o, l2_req_valid_o, c0_res_ready_o, c1_res_ready_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: grant=%b busy=%b err=%b l2v=%b r0=%b r1=%b required all 0",
               grant_o, busy_o, err_timeout_o, l2_req_valid_o, c0_res_ready_o, c1_res_ready_o);
    end
    total++;
    if (l2_req_addr_o !== '0 || l2_req_rw_o !== 1'b0 || c0_res_data_o !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h rw=%b rdata0=%h required 0", l2_req_addr_o, l2_req_rw_o, c0_res_data_o);
    end
`ifdef ARB_PERF_CNT_EN
    total++;
    if ({c0_grant_cnt_o, c1_grant_cnt_o, wait_cnt_o} !== 96'd0) begin
      bad++;
      $display("FAIL reset_perf: c0=%0d c1=%0d wait=%0d required 0", c0_grant_cnt_o, c1_grant_cnt_o, wait_cnt_o);
    end
`endif
    tick(); tick();
    rst_ni = 1;
    tick();
    total++;
    if (busy_o !== 1'b0 || grant_o !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: busy=%b grant=%b required 0 00", busy_o, grant_o);
    end
  endtask

  task automatic test_single();
    apply_reset();
    c0_req_valid_i = 1; c0_req_rw_i = 0; c0_req_addr_i = 32'h0000_1040;
    sb.push_back('{who: 1'b0, rw: 1'b0, addr: 32'h0000_1040, data: '0});
    tick();
    total++;
    if (grant_o !== 2'b01 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: grant=%b busy=%b required 01 1", grant_o, busy_o);
    end
    complete(3, {16{8'hA5}});
    c0_req_valid_i = 0;
    #1;
    total++;
    if (busy_o !== 1'b0 || grant_o !== 2'b00 || c0_res_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: busy=%b grant=%b r0=%b required 0 00 0", busy_o, grant_o, c0_res_ready_o);
    end
  endtask

  task automatic test_idle_stray();
    l2_res_ready_i = 1;
    l2_res_data_i = {4{32'hDEAD_BEEF}};
    #1;
    total++;
    if (c0_res_ready_o !== 1'b0 || c1_res_ready_o !== 1'b0 || l2_req_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stray_ready: r0=%b r1=%b l2v=%b required 0 0 0", c0_res_ready_o, c1_res_ready_o, l2_req_valid_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL stray_state: busy=%b required 0", busy_o);
    end
    l2_res_ready_i = 0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    c0_req_valid_i = 1; c0_req_addr_i = 32'h0000_A000;
    c1_req_valid_i = 1; c1_req_addr_i = 32'h0000_B000;
    sb.push_back('{who: 1'b0, rw: 1'b0, addr: 32'h0000_A000, data: '0});
    sb.push_back('{who: 1'b1, rw: 1'b0, addr: 32'h0000_B000, data: '0});
    sb.push_back('{who: 1'b0, rw: 1'b0, addr: 32'h0000_A040, data: '0});
    sb.push_back('{who: 1'b1, rw: 1'b0, addr: 32'h0000_B040, data: '0});
    tick();
    complete(1, {4{32'h1111_0000}});
    c0_req_addr_i = 32'h0000_A040;
    complete(2, {4{32'h2222_0000}});
    c1_req_addr_i = 32'h0000_B040;
    complete(0, {4{32'h3333_0000}});
    complete(1, {4{32'h4444_0000}});
    c0_req_valid_i = 0;
    c1_req_valid_i = 0;
    tick();
`ifdef ARB_PERF_CNT_EN
    total++;
    if (c0_grant_cnt_o !== 32'd2 || c1_grant_cnt_o !== 32'd2) begin
      bad++;
      $display("FAIL perf_grants: c0=%0d c1=%0d required 2 2", c0_grant_cnt_o, c1_grant_cnt_o);
    end
    total++;
    if (wait_cnt_o === 32'd0) begin
      bad++;
      $display("FAIL perf_wait: wait_cnt=%0d required nonzero", wait_cnt_o);
    end
    apply_reset();
    total++;
    if ({c0_grant_cnt_o, c1_grant_cnt_o, wait_cnt_o} !== 96'd0) begin
      bad++;
      $display("FAIL perf_reset: c0=%0d c1=%0d wait=%0d required 0", c0_grant_cnt_o, c1_grant_cnt_o, wait_cnt_o);
    end
`endif
  endtask

  task automatic test_wb_lock();
    apply_reset();
    c0_req_valid_i = 1; c0_req_rw_i = 1; c0_req_addr_i = 32'h0000_2000;
    c0_req_data_i = {4{32'hC0DE_0001}};
    c1_req_valid_i = 1; c1_req_rw_i = 0; c1_req_addr_i = 32'h0000_4000;
    sb.push_back('{who: 1'b0, rw: 1'b1, addr: 32'h0000_2000, data: {4{32'hC0DE_0001}}});
    sb.push_back('{who: 1'b0, rw: 1'b0, addr: 32'h0000_3000, data: '0});
    sb.push_back('{who: 1'b1, rw: 1'b0, addr: 32'h0000_4000, data: '0});
    tick();
    complete(1, '0);
    c0_req_rw_i = 0; c0_req_addr_i = 32'h0000_3000;
    #1;
    total++;
    if (grant_o !== 2'b01 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL wb_lock_hold: grant=%b busy=%b required 01 1", grant_o, busy_o);
    end
    complete(0, {4{32'h5A5A_5A5A}});
    c0_req_valid_i = 0;
    complete(0, {4{32'h6B6B_6B6B}});
    c1_req_valid_i = 0;
  endtask

  task automatic test_wb_nolock();
    apply_reset();
    n_c0_valid = 1; n_c0_rw = 1; n_c0_addr = 32'h0000_2000; n_c0_data = {4{32'hC0DE_0002}};
    n_c1_valid = 1; n_c1_rw = 0; n_c1_addr = 32'h0000_4000;
    tick();
    total++;
    if (n_grant !== 2'b01 || n_l2_rw !== 1'b1) begin
      bad++;
      $display("FAIL nolock_wb: grant=%b rw=%b required 01 1", n_grant, n_l2_rw);
    end
    n_l2_ready = 1;
    tick();
    n_l2_ready = 0;
    n_c0_rw = 0; n_c0_addr = 32'h0000_3000;
    total++;
    if (n_busy !== 1'b0) begin
      bad++;
      $display("FAIL nolock_idle: busy=%b required 0", n_busy);
    end
    tick();
    total++;
    if (n_grant !== 2'b10 || n_l2_addr !== 32'h0000_4000) begin
      bad++;
      $display("FAIL nolock_c1: grant=%b addr=%h required 10 00004000", n_grant, n_l2_addr);
    end
    n_l2_ready = 1;
    tick();
    n_l2_ready = 0;
    n_c1_valid = 0;
    tick();
    total++;
    if (n_grant !== 2'b01 || n_l2_addr !== 32'h0000_3000 || n_l2_rw !== 1'b0) begin
      bad++;
      $display("FAIL nolock_alloc: grant=%b addr=%h rw=%b required 01 00003000 0", n_grant, n_l2_addr, n_l2_rw);
    end
    n_l2_ready = 1;
    tick();
    n_l2_ready = 0;
    n_c0_valid = 0;
  endtask

  task automatic test_owner_abort();
    apply_reset();
    c1_req_valid_i = 1; c1_req_addr_i = 32'h0000_5000;
    tick();
    c0_req_valid_i = 1; c0_req_addr_i = 32'h0000_6000;
    total++;
    if (grant_o !== 2'b10 || l2_req_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL abort_grant: grant=%b l2v=%b required 10 1", grant_o, l2_req_valid_o);
    end
    c1_req_valid_i = 0;
    #1;
    total++;
    if (l2_req_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_drop: l2_req_valid_o=%b required 0", l2_req_valid_o);
    end
    tick();
    total++;
    if (busy_o !== 1'b0 || grant_o !== 2'b00) begin
      bad++;
      $display("FAIL abort_idle: busy=%b grant=%b required 0 00", busy_o, grant_o);
    end
    sb.push_back('{who: 1'b0, rw: 1'b0, addr: 32'h0000_6000, data: '0});
    tick();
    total++;
    if (grant_o !== 2'b01) begin
      bad++;
      $display("FAIL abort_next: grant=%b required 01", grant_o);
    end
    complete(0, {4{32'h7777_7777}});
    c0_req_valid_i = 0;
  endtask

  task automatic test_watchdog();
    apply_reset();
    c0_req_valid_i = 1; c0_req_addr_i = 32'h0000_7000;
    sb.push_back('{who: 1'b0, rw: 1'b0, addr: 32'h0000_7000, data: '0});
    tick();
    repeat (7) tick();
    total++;
    if (err_timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL wdog_early: err=%b after 7 stalls required 0", err_timeout_o);
    end
    tick();
    total++;
    if (err_timeout_o !== 1'b1) begin
      bad++;
      $display("FAIL wdog_set: err=%b after 8 stalls required 1", err_timeout_o);
    end
    complete(0, {4{32'h8888_8888}});
    c0_req_addr_i = 32'h0000_7040;
    total++;
    if (err_timeout_o !== 1'b1) begin
      bad++;
      $display("FAIL wdog_sticky: err=%b after completion required 1", err_timeout_o);
    end
    tick();
    #2;
    rst_ni = 0;
    #1;
    total++;
    if (l2_req_valid_o !== 1'b0 || grant_o !== 2'b00 || err_timeout_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: l2v=%b grant=%b err=%b busy=%b required 0 00 0 0",
               l2_req_valid_o, grant_o, err_timeout_o, busy_o);
    end
    clear_inputs();
    tick();
    rst_ni = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle_stray();
    test_round_robin();
    test_wb_lock();
    test_wb_nolock();
    test_owner_abort();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
